// File: rtl/freq_counter_mc.sv
// Multi-channel frequency / period counter for slow asynchronous inputs.
// Frequency mode counts rising edges per gate; period mode times edge-to-edge spacing.
module freq_counter_mc #(
   parameter int CHN  = 4,
   parameter int CW   = 32,
   parameter int SYNC = 2
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic [CHN-1:0]    sig_i,
   input  logic              enable_i,
   input  logic              mode_i,
   input  logic [CW-1:0]     gate_len_i,
   output logic [CHN*CW-1:0] res_o,
   output logic [CHN-1:0]    vld_o,
   output logic [CHN-1:0]    ovf_o
);

   typedef enum logic {MODE_FREQ = 1'b0, MODE_PERIOD = 1'b1} mode_e;
   typedef enum logic {CH_IDLE = 1'b0, CH_ARMED = 1'b1} arm_e;

   localparam logic [CW-1:0] CMAX = '1;

   logic [CHN-1:0]    sync_q [SYNC];
   logic [CHN-1:0]    hist_q;
   logic [CHN-1:0]    edge_w;
   logic              en_q;
   mode_e             mode_q, mode_d;
   logic [CW-1:0]     len_q, len_d, len_eff;
   logic [CW-1:0]     gcnt_q, gcnt_d;
   logic [CW-1:0]     cnt_q [CHN];
   logic [CW-1:0]     cnt_d [CHN];
   arm_e              arm_q [CHN];
   arm_e              arm_d [CHN];
   logic [CHN*CW-1:0] res_q, res_d;
   logic [CHN-1:0]    vld_q, vld_d;
   logic [CHN-1:0]    ovf_q, ovf_d;
   logic [CW:0]       sum_w [CHN];
   logic [CHN-1:0]    sat_w;
   logic              restart;
   logic              gate_end;

   always_comb begin
      edge_w   = sync_q[SYNC-1] & ~hist_q;
      len_eff  = (gate_len_i == '0) ? CW'(1) : gate_len_i;
      restart  = enable_i & (~en_q | (mode_e'(mode_i) != mode_q));
      gate_end = (gcnt_q == len_q - CW'(1));
      for (int unsigned k = 0; k < CHN; k++) begin
         sum_w[k] = {1'b0, cnt_q[k]} + {{CW{1'b0}}, edge_w[k]};
         sat_w[k] = (sum_w[k] >= {1'b0, CMAX});
      end
   end

   always_comb begin
      mode_d = mode_q;
      len_d  = len_q;
      gcnt_d = gcnt_q;
      cnt_d  = cnt_q;
      arm_d  = arm_q;
      res_d  = res_q;
      ovf_d  = ovf_q;
      vld_d  = '0;
      if (!enable_i) begin
         gcnt_d = '0;
         for (int unsigned k = 0; k < CHN; k++) begin
            cnt_d[k] = '0;
            arm_d[k] = CH_IDLE;
         end
      end else if (restart) begin
         mode_d = mode_e'(mode_i);
         len_d  = len_eff;
         gcnt_d = '0;
         for (int unsigned k = 0; k < CHN; k++) begin
            cnt_d[k] = '0;
            arm_d[k] = CH_IDLE;
         end
      end else if (mode_q == MODE_FREQ) begin
         // gate length is re-sampled at every wrap so mid-gate edits hit the next gate
         gcnt_d = gate_end ? '0 : gcnt_q + CW'(1);
         if (gate_end) len_d = len_eff;
         for (int unsigned k = 0; k < CHN; k++) begin
            if (gate_end) begin
               res_d[k*CW +: CW] = sat_w[k] ? CMAX : sum_w[k][CW-1:0];
               ovf_d[k]          = sat_w[k];
               vld_d[k]          = 1'b1;
               cnt_d[k]          = '0;
            end else begin
               cnt_d[k] = sat_w[k] ? CMAX : sum_w[k][CW-1:0];
            end
         end
      end else begin
         for (int unsigned k = 0; k < CHN; k++) begin
            case (arm_q[k])
               CH_IDLE: begin
                  if (edge_w[k]) begin
                     arm_d[k] = CH_ARMED;
                     cnt_d[k] = CW'(1);
                  end
               end
               CH_ARMED: begin
                  if (edge_w[k]) begin
                     res_d[k*CW +: CW] = cnt_q[k];
                     ovf_d[k]          = (cnt_q[k] == CMAX);
                     vld_d[k]          = 1'b1;
                     cnt_d[k]          = CW'(1);
                  end else if (cnt_q[k] >= len_q) begin
                     res_d[k*CW +: CW] = '0;
                     ovf_d[k]          = 1'b0;
                     vld_d[k]          = 1'b1;
                     arm_d[k]          = CH_IDLE;
                     cnt_d[k]          = '0;
                  end else begin
                     cnt_d[k] = (cnt_q[k] == CMAX) ? CMAX : cnt_q[k] + CW'(1);
                  end
               end
               default: arm_d[k] = CH_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sync_q <= '{default: '0};
         hist_q <= '0;
         en_q   <= 1'b0;
         mode_q <= MODE_FREQ;
         len_q  <= '0;
         gcnt_q <= '0;
         cnt_q  <= '{default: '0};
         arm_q  <= '{default: CH_IDLE};
         res_q  <= '0;
         vld_q  <= '0;
         ovf_q  <= '0;
      end else begin
         sync_q[0] <= sig_i;
         for (int unsigned i = 1; i < SYNC; i++) sync_q[i] <= sync_q[i-1];
         hist_q <= sync_q[SYNC-1];
         en_q   <= enable_i;
         mode_q <= mode_d;
         len_q  <= len_d;
         gcnt_q <= gcnt_d;
         cnt_q  <= cnt_d;
         arm_q  <= arm_d;
         res_q  <= res_d;
         vld_q  <= vld_d;
         ovf_q  <= ovf_d;
      end
   end

   assign res_o = res_q;
   assign vld_o = vld_q;
   assign ovf_o = ovf_q;

endmodule
